// File: rtl/gf64_power_seq.sv
// Sequential square-and-multiply exponentiator over GF(2^6): y = x^EXP, polynomial basis,
// p(z) = z^6 + z + 1. One word in flight, six RUN cycles per word, valid/ready both sides.
module gf64_power_seq #(
   parameter logic [5:0] EXP = 6'd26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [5:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [5:0] out_data,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Padded so the 3-bit counter can index it after wrapping past zero
   localparam logic [7:0] EXP_BITS = {2'b00, EXP};

   state_t     state_q, state_d;
   logic [5:0] acc_q, acc_d;
   logic [5:0] x_q, x_d;
   logic [2:0] cnt_q, cnt_d;
   logic [5:0] out_data_q, out_data_d;
   logic       out_valid_q, out_valid_d;
   logic [5:0] acc_step;
   logic       accept;

   function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
      logic [10:0] p;
      p = '0;
      for (int i = 0; i < 6; i++)
         if (b[i]) p = p ^ ({5'd0, a} << i);
      // Fold top-down so bits pushed into 6..9 by higher folds are reduced as well
      for (int i = 10; i >= 6; i--)
         if (p[i]) p = p ^ (11'd1 << i) ^ (11'd1 << (i - 5)) ^ (11'd1 << (i - 6));
      return p[5:0];
   endfunction

   function automatic logic [5:0] gf_sq(input logic [5:0] a);
      return gf_mul(a, a);
   endfunction

   assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q == RUN);

   always_comb begin
      acc_step = gf_sq(acc_q);
      if (EXP_BITS[cnt_q]) acc_step = gf_mul(acc_step, x_q);
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      x_d         = x_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: state_d = IDLE;
         RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd0) begin
               out_data_d  = acc_step;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A load can coincide with the DONE hand-off and goes straight back to RUN
      if (accept) begin
         x_d     = in_data;
         acc_d   = 6'h01;
         cnt_d   = 3'd5;
         state_d = RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= 6'h00;
         x_q         <= 6'h00;
         cnt_q       <= 3'd5;
         out_data_q  <= 6'h00;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         x_q         <= x_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: doc/gf64_power_seq.md
Name: gf64_power_seq

Overview:
- Sequential square-and-multiply exponentiator over GF(2^6). Computes y = x^EXP in polynomial basis, field polynomial p(z) = z^6 + z + 1.
- Sits directly downstream of the stimulus source and upstream of the tower-field power-map datapath. Serves as the clocked golden producer and checker of power-map values, with valid/ready on both sides.
- One word in flight; 6 processing cycles per word.

Parameters:
- EXP, 26, exponent applied to every input word; legal range 0..63, processed as 6 bits MSB-first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept a word this cycle
- in_data  input  6  field element x, polynomial basis, bit i = coefficient of z^i
- out_valid  output  1  out_data holds a finished result
- out_ready  input  1  consumer accepts the result this cycle
- out_data  output  6  x^EXP, polynomial basis
- busy  output  1  high in the RUN state

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, out_data=0, busy=0, accumulator=0, x register=0, bit counter=5. Effective immediately, not at the next edge. A word in flight is discarded; no partial result ever appears on out_data.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational, with no dependency on in_valid.
- Input accept at an edge with in_valid & in_ready:
  - Register x <= in_data, acc <= 6'h01, cnt <= 5, next state RUN.
  - in_data is ignored at all other times; changing in_data while in_ready=0 has no effect.
- RUN, one edge per exponent bit b = EXP[cnt]:
  - acc <= b ? mul(sq(acc), x) : sq(acc).
  - sq and mul are both reduced mod p(z) in the same cycle.
  - cnt decrements each edge.
  - At the edge with cnt==0: out_data <= new acc, out_valid <= 1, state <= DONE.
- Latency: word accepted at edge k, out_valid high after edge k+6. Exactly 6 edges in RUN, independent of EXP and x.
- DONE: out_valid=1, out_data stable until an edge with out_ready=1.
  - out_ready=1 and no new word accepted: out_valid <= 0, state <= IDLE. out_data keeps its last value.
  - Same edge also accepts a new word (in_valid=1): out_valid <= 0, state <= RUN directly, load as in the input accept.
  - Back-to-back throughput: one word per 7 cycles.
- Arithmetic rules:
  - mul is the carry-less 6x6 product giving 11 bits; fold bits 10..6 via z^6 = z + 1.
  - x=0 with EXP>0 gives 0.
  - EXP=0 gives 1 for every x, including x=0.
  - EXP=63 gives 1 for x≠0 and 0 for x=0.
- out_valid never drops without out_ready. out_data never changes while out_valid=1.
- No other outputs depend combinationally on inputs.

Test Plan:
- Reset and idle: assert rst mid-RUN (3 edges after accept) -> out_valid=0, out_data=0, in_ready=1 immediately; no result emitted after rst deasserts.
- Single word, EXP=26: in_data=0x02 accepted at edge k -> out_valid=1 after edge k+6 with out_data=0x07. in_data=0x04 -> 0x15. in_data=0x01 -> 0x01. in_data=0x00 -> 0x00.
- Backpressure: hold out_ready=0 for 10 cycles after a result -> out_valid stays 1, out_data stays 0x07, in_ready=0. Raise out_ready with in_valid=1, in_data=0x04 -> result accepted and new word loaded on the same edge; next result 0x15 appears 6 edges later.
- Busy gating: change in_data every cycle during RUN with in_valid=1 -> result reflects only the word sampled at accept; in_ready=0 and busy=1 for exactly 6 cycles.
- Exhaustive sweep, EXP=26: stream all 64 inputs with random out_ready stalls -> each out_data equals a software x^26 mod z^6+z+1; no drops or duplicates; order preserved.
- Parameter corners: EXP=0, x=0x00 -> 0x01. EXP=63, x=0x02 -> 0x01. EXP=63, x=0x00 -> 0x00. EXP=1, x=0x2B -> 0x2B.
